// File: rtl/pattern_checker_10b8b.sv
// Receive-side checker for the 8b10b link test pattern: hunts for the frame start, verifies
// every decoded byte against the fixed 268-byte frame, and keeps lock and error statistics.
module pattern_checker_10b8b #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned UNLOCK_ERRS = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        DVALID,
    input  logic        KI,
    input  logic [7:0]  DATAIN,
    input  logic        CODE_ERR,
    input  logic        CLR,
    output logic        LOCKED,
    output logic        ERR_PULSE,
    output logic [15:0] ERR_COUNT,
    output logic [15:0] FRAME_COUNT,
    output logic [1:0]  STATE
);

    typedef enum logic [1:0] {
        StHunt   = 2'b00,
        StSync   = 2'b01,
        StLocked = 2'b10
    } state_e;

    localparam logic [8:0] LastPos    = 9'd267;
    localparam logic [3:0] LockFrames = 4'(LOCK_FRAMES);
    localparam logic [3:0] UnlockErrs = 4'(UNLOCK_ERRS);

    state_e      state_q, state_d;
    logic [8:0]  pos_q, pos_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  cons_q, cons_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        err_pulse_q, err_pulse_d;
    logic        locked_q, locked_d;

    logic        exp_k;
    logic [7:0]  exp_d;
    logic        match;
    logic        sync_char;
    logic        last_pos;
    logic [8:0]  pos_inc;

    // Expected symbol at the current frame position
    always_comb begin
        exp_k = 1'b1;
        case (pos_q)
            9'd0:    exp_d = 8'h1C;
            9'd1:    exp_d = 8'h3C;
            9'd2:    exp_d = 8'h5C;
            9'd3:    exp_d = 8'h7C;
            9'd4:    exp_d = 8'h9C;
            9'd5:    exp_d = 8'hBC;
            9'd6:    exp_d = 8'hDC;
            9'd7:    exp_d = 8'hFC;
            9'd8:    exp_d = 8'hF7;
            9'd9:    exp_d = 8'hFB;
            9'd10:   exp_d = 8'hFD;
            9'd11:   exp_d = 8'hFE;
            default: begin
                exp_k = 1'b0;
                exp_d = pos_q[7:0] - 8'd12;
            end
        endcase
    end

    assign match     = DVALID && !CODE_ERR && (KI == exp_k) && (DATAIN == exp_d);
    assign sync_char = DVALID && KI && (DATAIN == 8'h1C);
    assign last_pos  = (pos_q == LastPos);
    assign pos_inc   = last_pos ? 9'd0 : pos_q + 9'd1;

    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        good_d        = good_q;
        cons_d        = cons_q;
        err_count_d   = err_count_q;
        frame_count_d = frame_count_q;
        err_pulse_d   = 1'b0;

        if (DVALID) begin
            case (state_q)
                StHunt: begin
                    if (sync_char) begin
                        pos_d   = 9'd1;
                        good_d  = 4'd0;
                        state_d = StSync;
                    end
                end
                StSync: begin
                    if (match) begin
                        pos_d = pos_inc;
                        if (last_pos) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 == LockFrames) begin
                                state_d = StLocked;
                                cons_d  = 4'd0;
                            end
                        end
                    end else if (sync_char) begin
                        // A stray frame start restarts alignment rather than dropping to hunt
                        pos_d  = 9'd1;
                        good_d = 4'd0;
                    end else begin
                        state_d = StHunt;
                        pos_d   = 9'd0;
                    end
                end
                StLocked: begin
                    pos_d = pos_inc;
                    if (last_pos) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end
                    if (match) begin
                        cons_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        cons_d      = cons_q + 4'd1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (cons_q + 4'd1 == UnlockErrs) begin
                            state_d = StHunt;
                            pos_d   = 9'd0;
                            cons_d  = 4'd0;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (CLR) begin
            err_count_d   = 16'd0;
            frame_count_d = 16'd0;
        end
    end

    assign locked_d = (state_d == StLocked);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= StHunt;
            pos_q         <= 9'd0;
            good_q        <= 4'd0;
            cons_q        <= 4'd0;
            err_count_q   <= 16'd0;
            frame_count_q <= 16'd0;
            err_pulse_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            good_q        <= good_d;
            cons_q        <= cons_d;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
            err_pulse_q   <= err_pulse_d;
            locked_q      <= locked_d;
        end
    end

    assign LOCKED      = locked_q;
    assign ERR_PULSE   = err_pulse_q;
    assign ERR_COUNT   = err_count_q;
    assign FRAME_COUNT = frame_count_q;
    assign STATE       = state_q;

endmodule
